// File: rtl/board_win_checker.sv
// board_win_checker: after a move lands in the 8x8 board RAM, reads back
// the cells around the placed piece and reports whether it completes four
// in a row. It scans horizontal, vertical and both diagonals, one read at
// a time, and never reads or counts an off-board cell.
module board_win_checker (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   input  logic [5:0] last_addr,
   input  logic [1:0] player,
   output logic [5:0] ram_addr,
   input  logic [1:0] ram_q,
   output logic       busy,
   output logic       done,
   output logic       win
);

   localparam int unsigned AW = 6;
   localparam int unsigned SW = 4;   // slot index 0..8, 8 means "no slots left"

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_CMP  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t         state;
   logic [AW-1:0]  addr_l;
   logic [1:0]     player_l;
   logic [1:0]     dir;
   logic           side;
   logic [1:0]     step;
   logic [1:0]     run;

   // A slot is {direction, side}; side 1 negates the offset.
   // Returns {in_range, target_addr} for step k along the slot.
   function automatic logic [AW:0] tgt(input logic [AW-1:0] base,
                                       input logic [2:0]    slot,
                                       input logic [1:0]    k);
      logic signed [4:0] dr;
      logic signed [4:0] dc;
      logic signed [4:0] kk;
      logic signed [4:0] r;
      logic signed [4:0] c;
      logic              ok;
      dr = 5'sd0;
      dc = 5'sd0;
      case (slot[2:1])
         2'd0:    dc = 5'sd1;
         2'd1:    dr = 5'sd1;
         2'd2:    begin dr = 5'sd1; dc = 5'sd1;  end
         default: begin dr = 5'sd1; dc = -5'sd1; end
      endcase
      if (slot[0]) begin
         dr = -dr;
         dc = -dc;
      end
      kk = $signed(5'(k));
      r  = $signed({2'b00, base[5:3]}) + dr * kk;
      c  = $signed({2'b00, base[2:0]}) + dc * kk;
      ok = (r[4:3] == 2'b00) && (c[4:3] == 2'b00);
      return {ok, r[2:0], c[2:0]};
   endfunction

   logic            match;
   logic            extend;
   logic [1:0]      run_inc;
   logic [AW-1:0]   srch_base;
   logic [SW-1:0]   srch_start;
   logic [1:0]      srch_k;
   logic            srch_ok;
   logic [2:0]      srch_slot;
   logic [1:0]      srch_kf;
   logic [AW-1:0]   srch_addr;
   logic [1:0]      run_next;
   logic [AW:0]     t;
   logic [1:0]      k_try;

   // Where the scan resumes: same side one step further after a match, otherwise the next side.
   always_comb begin
      match   = (ram_q == player_l);
      extend  = match && (step != 2'd3);
      run_inc = match ? run + 2'd1 : run;
      if (state == S_IDLE) begin
         srch_base  = last_addr;
         srch_start = '0;
         srch_k     = 2'd1;
      end else begin
         srch_base  = addr_l;
         srch_start = extend ? SW'({dir, side}) : SW'({dir, side}) + SW'(1);
         srch_k     = extend ? step + 2'd1 : 2'd1;
      end
   end

   // First in-range target at or after the resume point; off-board sides are skipped for free.
   always_comb begin
      srch_ok   = 1'b0;
      srch_slot = '0;
      srch_kf   = 2'd1;
      srch_addr = '0;
      t         = '0;
      k_try     = 2'd1;
      for (int s = 0; s < 8; s++) begin
         k_try = (SW'(s) == srch_start) ? srch_k : 2'd1;
         t     = tgt(srch_base, 3'(s), k_try);
         if (!srch_ok && (SW'(s) >= srch_start) && t[AW]) begin
            srch_ok   = 1'b1;
            srch_slot = 3'(s);
            srch_kf   = k_try;
            srch_addr = t[AW-1:0];
         end
      end
      run_next = (srch_slot[2:1] == dir) ? run_inc : 2'd0;
   end

   // Check sequencer: one RD/CMP pair per in-range neighbour, result in DONE.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state    <= S_IDLE;
         addr_l   <= '0;
         player_l <= '0;
         dir      <= '0;
         side     <= 1'b0;
         step     <= '0;
         run      <= '0;
         ram_addr <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         win      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  addr_l   <= last_addr;
                  player_l <= player;
                  win      <= 1'b0;
                  run      <= '0;
                  dir      <= '0;
                  side     <= 1'b0;
                  step     <= 2'd1;
                  busy     <= 1'b1;
                  if (player == 2'b00 || !srch_ok) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state    <= S_RD;
                     ram_addr <= srch_addr;
                     dir      <= srch_slot[2:1];
                     side     <= srch_slot[0];
                     step     <= srch_kf;
                  end
               end
            end
            S_RD: begin
               state <= S_CMP;
            end
            S_CMP: begin
               if (match && run == 2'd2) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  win   <= 1'b1;
               end else if (srch_ok) begin
                  state    <= S_RD;
                  ram_addr <= srch_addr;
                  dir      <= srch_slot[2:1];
                  side     <= srch_slot[0];
                  step     <= srch_kf;
                  run      <= run_next;
               end else begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  win   <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
